// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one fixed-latency multiplier
// among NREQ requesters. A tag pipe that mirrors the multiplier latency
// records the owner of each in-flight product. The owner receives the
// product as a registered, one-hot response.
module mul_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 3,
   parameter int W       = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [NREQ-1:0]              req_valid,
   output logic [NREQ-1:0]              req_ready,
   input  logic [NREQ*W-1:0]            req_a,
   input  logic [NREQ*W-1:0]            req_b,
   output logic                         mul_valid,
   output logic [W-1:0]                 mul_a,
   output logic [W-1:0]                 mul_b,
   input  logic [W-1:0]                 mul_result,
   output logic [NREQ-1:0]              rsp_valid,
   output logic [W-1:0]                 rsp_result,
   output logic [$clog2(MUL_LAT+2)-1:0] inflight,
   output logic                         idle
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(MUL_LAT+2);

   logic [IDW-1:0]               rr_ptr_q, rr_ptr_d;
   logic                         grant_found;
   logic [IDW-1:0]               grant_id;
   logic [IDW:0]                 idx_w;
   logic [MUL_LAT-1:0]           tag_vld_q;
   logic [MUL_LAT-1:0][IDW-1:0]  tag_id_q;
   logic [NREQ-1:0]              rsp_valid_q, rsp_valid_d;
   logic [W-1:0]                 rsp_result_q, rsp_result_d;
   logic [CW-1:0]                inflight_q, inflight_d;

   // Round-robin search starting at rr_ptr. The search is gated by reset so
   // that nothing is granted while reset is held.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      idx_w       = '0;
      if (en && rst_n) begin
         for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NREQ)) idx_w = idx_w - (IDW+1)'(NREQ);
            if (!grant_found && req_valid[idx_w[IDW-1:0]]) begin
               grant_found = 1'b1;
               grant_id    = idx_w[IDW-1:0];
            end
         end
      end
   end

   // Grant decode and operand pass-through to the multiplier.
   // The operands are zero when nothing is issued.
   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (grant_found) begin
         req_ready[grant_id] = 1'b1;
         mul_a = req_a[int'(grant_id)*W +: W];
         mul_b = req_b[int'(grant_id)*W +: W];
      end
   end

   assign mul_valid = grant_found;

   // Pointer moves past the winner only on a handshake.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_found) rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
   end

   // Arbitration pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

   // Tag pipe shifts every cycle regardless of en, so issued work always drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         tag_vld_q[0] <= grant_found;
         tag_id_q[0]  <= grant_id;
         for (int s = 1; s < MUL_LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end
      end
   end

   // Response capture and in-flight accounting.
   // The last tag stage lines up with mul_result.
   always_comb begin
      rsp_valid_d  = '0;
      rsp_result_d = rsp_result_q;
      if (tag_vld_q[MUL_LAT-1]) begin
         rsp_valid_d[tag_id_q[MUL_LAT-1]] = 1'b1;
         rsp_result_d = mul_result;
      end
      inflight_d = inflight_q;
      case ({grant_found, |rsp_valid_q})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Response and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         inflight_q   <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         inflight_q   <= inflight_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign inflight   = inflight_q;
   assign idle       = (inflight_q == '0) && !(|req_valid);

endmodule
